// File: rtl/async_fifo_gray.sv
// Dual-clock FIFO with Gray-coded pointer crossings, registered flags and levels.
// Optional sticky overflow/underflow flags are built only with ASYNC_FIFO_ERR_FLAGS_EN defined.
module async_fifo_gray #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int AF_THRESH   = 4,
  parameter int AE_THRESH   = 4
) (
  input  logic                     wr_clk,
  input  logic                     reset,
  input  logic                     rd_clk,
  input  logic                     wr_en,
  input  logic [DATA_WIDTH-1:0]    din,
  output logic                     full,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   wr_level,
  input  logic                     rd_en,
  output logic [DATA_WIDTH-1:0]    dout,
  output logic                     empty,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   rd_level,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] AF_LEVEL = PW'(DEPTH - AF_THRESH);
  localparam logic [PW-1:0] AE_LEVEL = PW'(AE_THRESH);

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  logic [PW-1:0] wr_bin_r, wr_gray_r, rd_bin_r, rd_gray_r;
  logic [PW-1:0] rq_r [SYNC_STAGES];
  logic [PW-1:0] wq_r [SYNC_STAGES];
  logic [PW-1:0] rq_last_s, wq_last_s;
  logic          full_r, almost_full_r, empty_r, almost_empty_r;
  logic [PW-1:0] wr_level_r, rd_level_r;
  logic [DATA_WIDTH-1:0] dout_r;

  logic          wr_accept_s, rd_accept_s, full_next_s, empty_next_s;
  logic [PW-1:0] wr_bin_next_s, wr_gray_next_s, rd_bin_next_s, rd_gray_next_s;
  logic [PW-1:0] wr_level_next_s, rd_level_next_s;

  assign rq_last_s = rq_r[SYNC_STAGES-1];
  assign wq_last_s = wq_r[SYNC_STAGES-1];

  // Write-side next pointer, occupancy and full detection
  always_comb begin
    wr_accept_s     = wr_en & ~full_r;
    wr_bin_next_s   = wr_bin_r + {{AW{1'b0}}, wr_accept_s};
    wr_gray_next_s  = bin2gray(wr_bin_next_s);
    wr_level_next_s = wr_bin_next_s - gray2bin(rq_last_s);
    // Full when the write pointer is one lap ahead: top two Gray bits inverted
    full_next_s     = (wr_gray_next_s == {~rq_last_s[PW-1:PW-2], rq_last_s[PW-3:0]});
  end

  // Read-side next pointer, occupancy and empty detection
  always_comb begin
    rd_accept_s     = rd_en & ~empty_r;
    rd_bin_next_s   = rd_bin_r + {{AW{1'b0}}, rd_accept_s};
    rd_gray_next_s  = bin2gray(rd_bin_next_s);
    rd_level_next_s = gray2bin(wq_last_s) - rd_bin_next_s;
    empty_next_s    = (rd_gray_next_s == wq_last_s);
  end

  // Read Gray pointer synchronizer into the write domain
  always_ff @(posedge wr_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) rq_r[i] <= {PW{1'b0}};
    end else begin
      rq_r[0] <= rd_gray_r;
      for (int i = 1; i < SYNC_STAGES; i++) rq_r[i] <= rq_r[i-1];
    end
  end

  // Write Gray pointer synchronizer into the read domain
  always_ff @(posedge rd_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) wq_r[i] <= {PW{1'b0}};
    end else begin
      wq_r[0] <= wr_gray_r;
      for (int i = 1; i < SYNC_STAGES; i++) wq_r[i] <= wq_r[i-1];
    end
  end

  // Write pointer, flags and level registers
  always_ff @(posedge wr_clk or posedge reset) begin
    if (reset) begin
      wr_bin_r      <= {PW{1'b0}};
      wr_gray_r     <= {PW{1'b0}};
      full_r        <= 1'b0;
      almost_full_r <= 1'b0;
      wr_level_r    <= {PW{1'b0}};
    end else begin
      wr_bin_r      <= wr_bin_next_s;
      wr_gray_r     <= wr_gray_next_s;
      full_r        <= full_next_s;
      almost_full_r <= (wr_level_next_s >= AF_LEVEL);
      wr_level_r    <= wr_level_next_s;
    end
  end

  // Storage array; contents need no reset since pointers define validity
  always_ff @(posedge wr_clk) begin
    if (wr_accept_s && !reset) begin
      mem_r[wr_bin_r[AW-1:0]] <= din;
    end
  end

  // Read pointer, registered data, flags and level registers
  always_ff @(posedge rd_clk or posedge reset) begin
    if (reset) begin
      rd_bin_r       <= {PW{1'b0}};
      rd_gray_r      <= {PW{1'b0}};
      empty_r        <= 1'b1;
      almost_empty_r <= 1'b1;
      rd_level_r     <= {PW{1'b0}};
      dout_r         <= {DATA_WIDTH{1'b0}};
    end else begin
      rd_bin_r       <= rd_bin_next_s;
      rd_gray_r      <= rd_gray_next_s;
      empty_r        <= empty_next_s;
      almost_empty_r <= (rd_level_next_s <= AE_LEVEL);
      rd_level_r     <= rd_level_next_s;
      if (rd_accept_s) begin
        dout_r <= mem_r[rd_bin_r[AW-1:0]];
      end
    end
  end

`ifdef ASYNC_FIFO_ERR_FLAGS_EN
  logic overflow_r, underflow_r;

  // Sticky overflow: write attempted while full
  always_ff @(posedge wr_clk or posedge reset) begin
    if (reset) begin
      overflow_r <= 1'b0;
    end else if (wr_en && full_r) begin
      overflow_r <= 1'b1;
    end
  end

  // Sticky underflow: read attempted while empty
  always_ff @(posedge rd_clk or posedge reset) begin
    if (reset) begin
      underflow_r <= 1'b0;
    end else if (rd_en && empty_r) begin
      underflow_r <= 1'b1;
    end
  end

  assign overflow  = overflow_r;
  assign underflow = underflow_r;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  assign full         = full_r;
  assign almost_full  = almost_full_r;
  assign wr_level     = wr_level_r;
  assign empty        = empty_r;
  assign almost_empty = almost_empty_r;
  assign rd_level     = rd_level_r;
  assign dout         = dout_r;

endmodule

// File: tb/tb_async_fifo_gray.sv
// Scoreboard bench for async_fifo_gray (DEPTH=16, 8-bit); follows ASYNC_FIFO_ERR_FLAGS_EN for flag expectations.
`timescale 1ns/1ps
module tb_async_fifo_gray;

  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int N_RAND = 5000;
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic wr_clk = 1'b0, rd_clk = 1'b0, reset = 1'b1;
  logic wr_en = 1'b0, rd_en = 1'b0;
  logic [DW-1:0] din = 8'h00;
  logic full, almost_full, empty, almost_empty, overflow, underflow;
  logic [LW-1:0] wr_level, rd_level;
  logic [DW-1:0] dout;

  realtime wr_half = 5.0;
  realtime rd_half = 13.5;
  always #(wr_half) wr_clk = ~wr_clk;
  always #(rd_half) rd_clk = ~rd_clk;

  async_fifo_gray #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .SYNC_STAGES(2), .AF_THRESH(4), .AE_THRESH(4)) dut (
    .wr_clk(wr_clk), .reset(reset), .rd_clk(rd_clk),
    .wr_en(wr_en), .din(din), .full(full), .almost_full(almost_full), .wr_level(wr_level),
    .rd_en(rd_en), .dout(dout), .empty(empty), .almost_empty(almost_empty), .rd_level(rd_level),
    .overflow(overflow), .underflow(underflow)
  );

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] sb[$];
  logic [DW-1:0] last_rd = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_cycle(input logic en, input logic [DW-1:0] d, output logic acc);
    @(negedge wr_clk);
    wr_en = en;
    din = d;
    acc = en && !full;
    @(posedge wr_clk);
    if (acc) sb.push_back(d);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic rd_cycle(input logic en, output logic acc);
    logic [DW-1:0] exp_d;
    @(negedge rd_clk);
    rd_en = en;
    acc = en && !empty;
    @(posedge rd_clk);
    #1;
    rd_en = 1'b0;
    if (acc) begin
      if (sb.size() == 0) begin
        check("sb_nonempty_on_read", 32'(sb.size()), 32'd1);
      end else begin
        exp_d = sb.pop_front();
        last_rd = exp_d;
        check("dout", 32'(dout), 32'(exp_d));
      end
    end
  endtask

  task automatic wait_wr(input int n);
    repeat (n) @(posedge wr_clk);
    #1;
  endtask

  task automatic wait_rd(input int n);
    repeat (n) @(posedge rd_clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_empty"}, 32'(empty), 32'd1);
    check({tag, "_almost_empty"}, 32'(almost_empty), 32'd1);
    check({tag, "_full"}, 32'(full), 32'd0);
    check({tag, "_almost_full"}, 32'(almost_full), 32'd0);
    check({tag, "_wr_level"}, 32'(wr_level), 32'd0);
    check({tag, "_rd_level"}, 32'(rd_level), 32'd0);
    check({tag, "_dout"}, 32'(dout), 32'd0);
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
    check({tag, "_underflow"}, 32'(underflow), 32'd0);
  endtask

  initial begin
    logic acc;
    int lat;

    // Reset state
    #23;
    check_reset_vals("rst");
    @(negedge wr_clk);
    reset = 1'b0;
    wait_wr(3);

    // Fill 0x01..0x10 then drain in order
    for (int i = 1; i <= DEPTH; i++) begin
      wr_cycle(1'b1, 8'(i), acc);
      if (i == DEPTH - 1) check("full_at_15", 32'(full), 32'd0);
    end
    check("full_at_16", 32'(full), 32'd1);
    check("wr_level_16", 32'(wr_level), 32'd16);
    check("almost_full_16", 32'(almost_full), 32'd1);
    wait_rd(6);
    check("rd_level_16", 32'(rd_level), 32'd16);
    check("empty_at_16", 32'(empty), 32'd0);
    rd_cycle(1'b1, acc);
    lat = 0;
    while (full && lat < 8) begin
      @(posedge wr_clk);
      #1;
      lat++;
    end
    check("full_release_within_4", 32'(lat <= 4 && !full), 32'd1);
    for (int i = 1; i < DEPTH; i++) rd_cycle(1'b1, acc);
    check("empty_after_16_reads", 32'(empty), 32'd1);
    check("rd_level_drained", 32'(rd_level), 32'd0);
    wait_wr(6);
    check("wr_level_drained", 32'(wr_level), 32'd0);
    check("full_drained", 32'(full), 32'd0);

    // Overflow: 17 writes with reads idle
    for (int i = 0; i <= DEPTH; i++) begin
      wr_cycle(1'b1, 8'(8'h40 + i), acc);
      if (i == DEPTH) check("wr17_dropped", 32'(acc), 32'd0);
    end
    check("ovf_wr_level", 32'(wr_level), 32'd16);
    check("overflow_flag", 32'(overflow), 32'(EXP_ERR));
    wait_rd(6);
    for (int i = 0; i < DEPTH; i++) rd_cycle(1'b1, acc);
    check("ovf_sb_drained", 32'(sb.size()), 32'd0);
    check("ovf_readback_last", 32'(last_rd), 32'h4f);
    check("ovf_empty", 32'(empty), 32'd1);

    // Underflow: read pulse while empty
    rd_cycle(1'b1, acc);
    check("udf_not_accepted", 32'(acc), 32'd0);
    check("udf_dout_held", 32'(dout), 32'(last_rd));
    check("udf_rd_level", 32'(rd_level), 32'd0);
    check("underflow_flag", 32'(underflow), 32'(EXP_ERR));
    wait_wr(6);

    // Almost-full / almost-empty thresholds and crossing latency
    wr_cycle(1'b1, 8'h80, acc);
    lat = 0;
    while (empty && lat < 8) begin
      @(posedge rd_clk);
      #1;
      lat++;
    end
    check("empty_release_within_4", 32'(lat <= 4 && !empty), 32'd1);
    for (int i = 1; i < 11; i++) wr_cycle(1'b1, 8'(8'h80 + i), acc);
    check("af_at_11", 32'(almost_full), 32'd0);
    check("wr_level_11", 32'(wr_level), 32'd11);
    wr_cycle(1'b1, 8'h8b, acc);
    check("af_at_12", 32'(almost_full), 32'd1);
    check("wr_level_12", 32'(wr_level), 32'd12);
    wait_rd(6);
    check("rd_level_12", 32'(rd_level), 32'd12);
    check("ae_at_12", 32'(almost_empty), 32'd0);
    for (int i = 0; i < 7; i++) rd_cycle(1'b1, acc);
    check("rd_level_5", 32'(rd_level), 32'd5);
    check("ae_at_5", 32'(almost_empty), 32'd0);
    rd_cycle(1'b1, acc);
    check("rd_level_4", 32'(rd_level), 32'd4);
    check("ae_at_4", 32'(almost_empty), 32'd1);
    wait_wr(5);
    check("wr_level_4", 32'(wr_level), 32'd4);
    check("af_at_4", 32'(almost_full), 32'd0);
    for (int i = 0; i < 4; i++) rd_cycle(1'b1, acc);
    check("thr_empty", 32'(empty), 32'd1);

    // Mid-operation reset after 9 writes and 3 reads
    for (int i = 0; i < 9; i++) wr_cycle(1'b1, 8'(8'h90 + i), acc);
    wait_rd(5);
    for (int i = 0; i < 3; i++) rd_cycle(1'b1, acc);
    @(negedge wr_clk);
    wr_en = 1'b1;
    rd_en = 1'b1;
    reset = 1'b1;
    #1;
    check_reset_vals("midrst");
    wait_rd(3);
    check_reset_vals("midrst_held");
    wr_en = 1'b0;
    rd_en = 1'b0;
    sb.delete();
    @(negedge wr_clk);
    reset = 1'b0;
    wait_wr(3);
    wr_cycle(1'b1, 8'hAA, acc);
    wait_rd(5);
    rd_cycle(1'b1, acc);
    check("post_rst_accept", 32'(acc), 32'd1);
    check("post_rst_dout", 32'(dout), 32'hAA);

    // Random traffic at both clock ratios
    for (int ph = 0; ph < 2; ph++) begin
      if (ph == 1) begin
        wr_half = 13.5;
        rd_half = 5.0;
      end
      fork
        begin
          logic wacc;
          int wn, wcyc;
          wn = 0;
          wcyc = 0;
          while (wn < N_RAND && wcyc < 40000) begin
            wr_cycle(1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)), wacc);
            if (wacc) wn++;
            wcyc++;
          end
          check("rand_writes_done", 32'(wn), 32'(N_RAND));
        end
        begin
          logic racc;
          int rn, rcyc;
          rn = 0;
          rcyc = 0;
          while (rn < N_RAND && rcyc < 40000) begin
            rd_cycle(1'($urandom_range(0, 7) != 0), racc);
            if (racc) rn++;
            rcyc++;
          end
          check("rand_reads_done", 32'(rn), 32'(N_RAND));
        end
      join
      check("rand_sb_empty", 32'(sb.size()), 32'd0);
      wait_rd(4);
      check("rand_final_empty", 32'(empty), 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/async_fifo_gray.md
ASYNC_FIFO_GRAY -- requirements
Module: async_fifo_gray

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, word count; power of two, >= 4.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, flops per pointer crossing; legal range 2..4.
REQ-004 SHALL have parameter AF_THRESH, default 4, almost_full margin in words.
REQ-005 SHALL have parameter AE_THRESH, default 4, almost_empty level in words.
REQ-006 SHALL have port wr_clk  input  1  write clock; reset reset, asynchronous, active-high; clock wr_clk.
REQ-007 SHALL have port reset  input  1  asynchronous active-high reset for both domains.
REQ-008 SHALL have port rd_clk  input  1  read clock, asynchronous to wr_clk.
REQ-009 SHALL have port wr_en  input  1  write request (wr_clk).
REQ-010 SHALL have port din  input  DATA_WIDTH  write data.
REQ-011 SHALL have ports full, almost_full  output  1 each, wr_clk domain.
REQ-012 SHALL have port wr_level  output  $clog2(DEPTH)+1  occupancy as seen by the write side.
REQ-013 SHALL have port rd_en  input  1  read request (rd_clk).
REQ-014 SHALL have port dout  output  DATA_WIDTH  registered read data.
REQ-015 SHALL have ports empty, almost_empty  output  1 each, rd_clk domain.
REQ-016 SHALL have port rd_level  output  $clog2(DEPTH)+1  occupancy as seen by the read side.
REQ-017 SHALL have ports overflow (wr_clk) and underflow (rd_clk)  output  1 each; sticky error flags.

Function
REQ-018 SHALL keep binary and Gray pointers, $clog2(DEPTH)+1 bits each; the MSB is the wrap bit; only Gray pointers cross domains, through SYNC_STAGES flops.
REQ-019 SHALL accept a write only when wr_en=1 and full=0, store din at wr_ptr[MSB-1:0] and increment wr_ptr at that wr_clk edge; wr_en while full is dropped and leaves contents unchanged.
REQ-020 SHALL accept a read only when rd_en=1 and empty=0, increment rd_ptr, and present the addressed word on dout at that same rd_clk edge (1-cycle latency); dout holds its value when no read is accepted.
REQ-021 SHALL register full from the next write pointer; full=1 on the edge that accepts the DEPTH-th unread word.
REQ-022 SHALL register empty from the next read pointer; empty=1 on the edge that accepts the last word.
REQ-023 SHALL compute wr_level = wr_ptr - sync(rd_ptr) and rd_level = sync(wr_ptr) - rd_ptr modulo 2^($clog2(DEPTH)+1), each registered in its own domain; range 0..DEPTH.
REQ-024 SHALL drive almost_full=1 when wr_level >= DEPTH-AF_THRESH, and almost_empty=1 when rd_level <= AE_THRESH.
REQ-025 SHALL make a write visible to the read side (empty 1->0) within SYNC_STAGES+2 rd_clk edges; a read frees space (full 1->0) within SYNC_STAGES+2 wr_clk edges. Flags SHALL be conservative and never falsely deassert.
REQ-026 SHALL handle simultaneous read and write at any level, including the full and empty boundaries, and pointer wrap past 2*DEPTH, without losing or duplicating data.

Reset
REQ-027 SHALL on reset=1 clear all pointers and sync flops and drive empty=1, almost_empty=1, full=0, almost_full=0, wr_level=0, rd_level=0, dout=0, overflow=0, underflow=0.
REQ-028 SHALL discard all contents on a reset asserted mid-operation; the first write after release is the first word read.
REQ-029 SHALL ignore wr_en and rd_en while reset=1.

Configuration
REQ-030 SHALL compile the error-flag logic only with macro ASYNC_FIFO_ERR_FLAGS_EN defined: overflow is set by wr_en=1 while full=1, underflow by rd_en=1 while empty=1, and both stay set until reset.
REQ-031 SHALL, with ASYNC_FIFO_ERR_FLAGS_EN undefined, keep the overflow and underflow ports and tie them to constant 0.

Verification (DATA_WIDTH=8, DEPTH=16, wr_clk 100 MHz, rd_clk 37 MHz)
REQ-032 Write 0x01..0x10, then read 16 -> dout returns 0x01..0x10 in order; full=1 after the 16th write; empty=1 after the 16th read.
REQ-033 Write 17 words while reads are idle -> the 17th is dropped, wr_level=16; with the macro defined overflow=1; readback ends at the 16th word.
REQ-034 With the FIFO empty, pulse rd_en -> dout unchanged, rd_level=0; underflow=1 with the macro defined, 0 without.
REQ-035 Continuous random wr_en/rd_en for 10,000 words across clock ratios 100/37 and 37/100 MHz -> scoreboard match, no false full/empty, pointers wrap repeatedly.
REQ-036 Fill to 12 -> almost_full=1 (16-4); drain to 4 -> almost_empty=1; rd_level then wr_level track within the REQ-025 bounds.
REQ-037 Assert reset after 9 writes and 3 reads -> all outputs at REQ-027 values; after release write 0xAA, read -> dout=0xAA.
